frame_tag_sched: RTL and testbench



---
 rtl/frame_tag_sched_if.sv | 37 +++
 rtl/frame_tag_sched.sv | 150 +++++++++++++++
 tb/tb_frame_tag_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_tag_sched_if.sv
// frame_tag_sched_if: pixel-in / FIFO-write bundle for the frame tag scheduler.
//
// Signals:
//   frame_start  single-cycle start-of-frame pulse (source -> scheduler)
//   pix_valid    pix_data valid this cycle, no backpressure (source -> scheduler)
//   pix_data     16-bit pixel payload (source -> scheduler)
//   fifo_full    FIFO full flag (FIFO -> scheduler)
//   fifo_wr_en   FIFO write strobe (scheduler -> FIFO)
//   fifo_din     tagged word {x[1:0], y[10:0], data[15:0]} (scheduler -> FIFO)
//
// master: the scheduler. slave: the pixel source plus FIFO environment.
interface frame_tag_sched_if;
    logic        frame_start;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [28:0] fifo_din;

    modport master (
        input  frame_start,
        input  pix_valid,
        input  pix_data,
        input  fifo_full,
        output fifo_wr_en,
        output fifo_din
    );

    modport slave (
        output frame_start,
        output pix_valid,
        output pix_data,
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_din
    );
endinterface

// File: rtl/frame_tag_sched.sv
// frame_tag_sched: write-side scheduler for the 29-bit tagged pixel FIFO.
//
// Tags each accepted 16-bit pixel with its half-line index x and line number y,
// writes {x[1:0], y[10:0], data[15:0]} to the FIFO, sequences frames, drops
// words while the FIFO is full and reports short frames and drop counts.
//
// Parameters:
//   H_SEG    pixels per half-line segment
//   V_LINES  lines per frame
// Ports:
//   clk125m      system clock, rising edge
//   reset_n      asynchronous active-low reset
//   en           scheduler enable; low forces IDLE and clears the counters
//   bus          pixel stream in / FIFO write port out (master modport)
//   frame_done   one-cycle pulse after the last word of a complete frame
//   short_frame  sticky: frame_start arrived mid-frame
//   overflow     sticky: at least one word dropped
//   drop_cnt     dropped-word count, saturating
//   busy         high while in RUN
module frame_tag_sched #(
    parameter int unsigned H_SEG   = 640,
    parameter int unsigned V_LINES = 720
) (
    input  logic                      clk125m,
    input  logic                      reset_n,
    input  logic                      en,
    frame_tag_sched_if.master         bus,
    output logic                      frame_done,
    output logic                      short_frame,
    output logic                      overflow,
    output logic [15:0]               drop_cnt,
    output logic                      busy
);

    localparam int unsigned CntW = (H_SEG > 1) ? $clog2(H_SEG) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(H_SEG - 1);
    localparam logic [10:0]     YLast   = 11'(V_LINES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitSof,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            x_q;
    logic [10:0]     y_q;

    logic            in_run, in_wait;
    logic            cur_last, last_hit, restart, accept, write, drop, mid_frame;
    logic [CntW-1:0] cnt_tag, cnt_adv;
    logic            x_tag, x_adv;
    logic [10:0]     y_tag, y_adv;

    always_comb begin
        in_run    = (state_q == StRun);
        in_wait   = (state_q == StWaitSof);
        cur_last  = x_q && (y_q == YLast) && (cnt_q == CntLast);
        mid_frame = (cnt_q != '0) || x_q || (y_q != '0);

        // The last pixel of a frame outranks a coincident frame_start: it keeps its
        // own coordinates and the new frame begins from zero after it.
        last_hit  = en && in_run && bus.pix_valid && cur_last;
        restart   = en && bus.frame_start && (in_wait || (in_run && !last_hit));
        accept    = en && bus.pix_valid && (in_run || restart);
        write     = accept && !bus.fifo_full;
        drop      = accept && bus.fifo_full;

        // Coordinates carried by the word accepted this cycle.
        cnt_tag   = restart ? '0 : cnt_q;
        x_tag     = restart ? 1'b0 : x_q;
        y_tag     = restart ? 11'd0 : y_q;

        // Counter advance from the tagged position, independent of drops so the
        // downstream checker sees a gap rather than shifted tags.
        cnt_adv   = cnt_tag + 1'b1;
        x_adv     = x_tag;
        y_adv     = y_tag;
        if (cnt_tag == CntLast) begin
            cnt_adv = '0;
            x_adv   = ~x_tag;
            if (x_tag) begin
                y_adv = (y_tag == YLast) ? 11'd0 : y_tag + 11'd1;
            end
        end

        state_d = state_q;
        if (!en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StWaitSof;
                StWaitSof: state_d = restart ? StRun : StWaitSof;
                StRun:     state_d = (last_hit && !bus.frame_start) ? StWaitSof : StRun;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk125m or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            x_q            <= 1'b0;
            y_q            <= 11'd0;
            bus.fifo_wr_en <= 1'b0;
            bus.fifo_din   <= 29'd0;
            frame_done     <= 1'b0;
            short_frame    <= 1'b0;
            overflow       <= 1'b0;
            drop_cnt       <= 16'd0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy           <= (state_d == StRun);
            frame_done     <= last_hit;
            bus.fifo_wr_en <= write;
            if (write) begin
                bus.fifo_din <= {1'b0, x_tag, y_tag, bus.pix_data};
            end

            if (!en || last_hit) begin
                cnt_q <= '0;
                x_q   <= 1'b0;
                y_q   <= 11'd0;
            end else if (accept) begin
                cnt_q <= cnt_adv;
                x_q   <= x_adv;
                y_q   <= y_adv;
            end else if (restart) begin
                cnt_q <= '0;
                x_q   <= 1'b0;
                y_q   <= 11'd0;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end

            if (restart && in_run && mid_frame) begin
                short_frame <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_tag_sched.sv
// Self-checking bench for frame_tag_sched with H_SEG=4, V_LINES=3.
module tb_frame_tag_sched;

    logic        clk125m = 1'b0;
    logic        reset_n = 1'b0;
    logic        en      = 1'b0;
    logic        frame_done, short_frame, overflow, busy;
    logic [15:0] drop_cnt;

    frame_tag_sched_if bus_if ();

    frame_tag_sched #(
        .H_SEG   (4),
        .V_LINES (3)
    ) dut (
        .clk125m     (clk125m),
        .reset_n     (reset_n),
        .en          (en),
        .bus         (bus_if),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #4 clk125m = ~clk125m;

    typedef struct {
        logic        en;
        logic        fs;
        logic        pv;
        logic        full;
        logic [15:0] data;
        logic        ewr;
        logic [28:0] edin;
        logic        edone;
        logic        ebusy;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected tag for pixel index i of a 4x2x3 frame.
    function automatic logic [28:0] tag(input int i, input logic [15:0] d);
        int x;
        int y;
        x = (i / 4) % 2;
        y = (i / 8) % 3;
        return {1'b0, x[0], y[10:0], d};
    endfunction

    task automatic push(input logic e, input logic fs, input logic pv, input logic full,
                        input logic [15:0] d, input logic ewr, input logic [28:0] edin,
                        input logic edone, input logic ebusy);
        vec_t v;
        v.en = e; v.fs = fs; v.pv = pv; v.full = full; v.data = d;
        v.ewr = ewr; v.edin = edin; v.edone = edone; v.ebusy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int from, input int to);
        for (int k = from; k < to; k++) begin
            @(negedge clk125m);
            en                 = vecs[k].en;
            bus_if.frame_start = vecs[k].fs;
            bus_if.pix_valid   = vecs[k].pv;
            bus_if.fifo_full   = vecs[k].full;
            bus_if.pix_data    = vecs[k].data;
            @(posedge clk125m);
            #1;
            chk($sformatf("wr_en[%0d]", k), 32'(bus_if.fifo_wr_en), 32'(vecs[k].ewr));
            if (vecs[k].ewr) begin
                chk($sformatf("din[%0d]", k), 32'(bus_if.fifo_din), 32'(vecs[k].edin));
            end
            chk($sformatf("done[%0d]", k), 32'(frame_done), 32'(vecs[k].edone));
            chk($sformatf("busy[%0d]", k), 32'(busy), 32'(vecs[k].ebusy));
        end
        @(negedge clk125m);
        bus_if.frame_start = 1'b0;
        bus_if.pix_valid   = 1'b0;
        bus_if.fifo_full   = 1'b0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_wr_en"}, 32'(bus_if.fifo_wr_en), 32'd0);
        chk({pfx, "_din"}, 32'(bus_if.fifo_din), 32'd0);
        chk({pfx, "_done"}, 32'(frame_done), 32'd0);
        chk({pfx, "_short"}, 32'(short_frame), 32'd0);
        chk({pfx, "_ovf"}, 32'(overflow), 32'd0);
        chk({pfx, "_drop"}, 32'(drop_cnt), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int m0, m_a, m_d, m_e, m_b, m_c, m_f;
        logic f;

        bus_if.frame_start = 1'b0;
        bus_if.pix_valid   = 1'b0;
        bus_if.fifo_full   = 1'b0;
        bus_if.pix_data    = 16'd0;

        // ---- build vector table ----
        m0 = vecs.size();
        push(1, 0, 0, 0, 16'd0, 0, 29'd0, 0, 0);                 // IDLE -> WAIT_SOF
        // A: one clean frame, then pixel ignored in WAIT_SOF
        push(1, 1, 0, 0, 16'd0, 0, 29'd0, 0, 1);
        for (int i = 0; i < 24; i++)
            push(1, 0, 1, 0, 16'(i), 1, tag(i, 16'(i)), i == 23, i != 23);
        push(1, 0, 1, 0, 16'h5555, 0, 29'd0, 0, 0);
        m_a = vecs.size();
        // D: more WAIT_SOF pixels, then frame_start with pixel
        for (int k = 0; k < 4; k++) push(1, 0, 1, 0, 16'(k), 0, 29'd0, 0, 0);
        push(1, 1, 1, 0, 16'hABCD, 1, 29'h0000ABCD, 0, 1);
        for (int i = 1; i < 24; i++)
            push(1, 0, 1, 0, 16'(100 + i), 1, tag(i, 16'(100 + i)), i == 23, i != 23);
        m_d = vecs.size();
        // E: last pixel coincident with frame_start, then a frame with no frame_start
        push(1, 1, 0, 0, 16'd0, 0, 29'd0, 0, 1);
        for (int i = 0; i < 23; i++)
            push(1, 0, 1, 0, 16'(200 + i), 1, tag(i, 16'(200 + i)), 0, 1);
        push(1, 1, 1, 0, 16'd223, 1, tag(23, 16'd223), 1, 1);
        for (int i = 0; i < 24; i++)
            push(1, 0, 1, 0, 16'(300 + i), 1, tag(i, 16'(300 + i)), i == 23, i != 23);
        m_e = vecs.size();
        // B: FIFO full on pixels 5..7
        push(1, 1, 0, 0, 16'd0, 0, 29'd0, 0, 1);
        for (int i = 0; i < 24; i++) begin
            f = (i >= 4 && i <= 6);
            push(1, 0, 1, f, 16'(400 + i), !f, tag(i, 16'(400 + i)), i == 23, i != 23);
        end
        m_b = vecs.size();
        // C: frame_start after 10 pixels, then full frame
        push(1, 1, 0, 0, 16'd0, 0, 29'd0, 0, 1);
        for (int i = 0; i < 10; i++)
            push(1, 0, 1, 0, 16'(500 + i), 1, tag(i, 16'(500 + i)), 0, 1);
        push(1, 1, 0, 0, 16'd0, 0, 29'd0, 0, 1);
        for (int i = 0; i < 24; i++)
            push(1, 0, 1, 0, 16'(600 + i), 1, tag(i, 16'(600 + i)), i == 23, i != 23);
        m_c = vecs.size();
        // F: en drop mid-frame, re-enable, restart and stop mid-frame
        push(1, 1, 0, 0, 16'd0, 0, 29'd0, 0, 1);
        for (int i = 0; i < 3; i++)
            push(1, 0, 1, 0, 16'(700 + i), 1, tag(i, 16'(700 + i)), 0, 1);
        push(0, 0, 1, 0, 16'd703, 0, 29'd0, 0, 0);
        push(1, 0, 1, 0, 16'd704, 0, 29'd0, 0, 0);
        push(1, 0, 1, 0, 16'd705, 0, 29'd0, 0, 0);
        push(1, 1, 1, 0, 16'd706, 1, tag(0, 16'd706), 0, 1);
        for (int i = 1; i < 6; i++)
            push(1, 0, 1, 0, 16'(800 + i), 1, tag(i, 16'(800 + i)), 0, 1);
        m_f = vecs.size();

        // ---- reset state ----
        repeat (2) @(posedge clk125m);
        #1;
        chk_all_zero("reset");
        @(negedge clk125m);
        reset_n = 1'b1;

        run_vecs(m0, m_a);
        chk("drop_after_wait_sof", 32'(drop_cnt), 32'd0);
        run_vecs(m_a, m_d);
        chk("drop_after_sof_pixel", 32'(drop_cnt), 32'd0);
        run_vecs(m_d, m_e);
        chk("short_after_last_plus_sof", 32'(short_frame), 32'd0);
        chk("ovf_before_full", 32'(overflow), 32'd0);
        run_vecs(m_e, m_b);
        chk("drop_cnt_3", 32'(drop_cnt), 32'd3);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("short_still_0", 32'(short_frame), 32'd0);
        run_vecs(m_b, m_c);
        chk("short_set", 32'(short_frame), 32'd1);
        chk("drop_cnt_kept", 32'(drop_cnt), 32'd3);
        run_vecs(m_c, m_f);
        chk("sticky_kept_after_en", 32'(overflow), 32'd1);

        // ---- asynchronous reset mid-frame, between clock edges ----
        #1;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk125m);
        @(negedge clk125m);
        reset_n            = 1'b1;
        en                 = 1'b1;
        bus_if.pix_valid   = 1'b1;
        bus_if.pix_data    = 16'h1234;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk125m);
            #1;
            chk($sformatf("post_reset_wr[%0d]", k), 32'(bus_if.fifo_wr_en), 32'd0);
            chk($sformatf("post_reset_busy[%0d]", k), 32'(busy), 32'd0);
        end
        chk("post_reset_drop", 32'(drop_cnt), 32'd0);
        bus_if.pix_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
